fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning the byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address, which is the base of the ROM window.
REQ-004 SHALL have parameter DEPTH, default 4, meaning the number of instruction buffer entries; it is a power of 2 and at least 2.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 fetch_en  in  1  enables issuing of new ROM requests.
REQ-008 redirect  in  1  branch or jump taken; fetch restarts at redirect_pc.
REQ-009 redirect_pc  in  ADDRESS_WIDTH  the new fetch address.
REQ-010 rom_req  out  1  ROM request valid.
REQ-011 rom_addr  out  ADDRESS_WIDTH  ROM byte address, word-aligned.
REQ-012 rom_gnt  in  1  the ROM has accepted the request this cycle.
REQ-013 rom_rvalid  in  1  the ROM is returning data this cycle; responses return in order, at least 1 cycle after the grant.
REQ-014 rom_rdata  in  DATA_WIDTH  the little-endian assembled instruction word.
REQ-015 instr_valid  out  1  the buffer head is valid.
REQ-016 instr_ready  in  1  decode accepts the head.
REQ-017 instr  out  DATA_WIDTH  the head instruction.
REQ-018 instr_pc  out  ADDRESS_WIDTH  the byte address of the head instruction.

Function
REQ-019 SHALL implement an FSM with three states: IDLE, RUN and FLUSH.
REQ-020 IDLE->RUN SHALL occur when fetch_en=1; RUN->IDLE SHALL occur when fetch_en=0.
REQ-021 Any state->FLUSH SHALL occur on redirect when the outstanding count (counting any grant in the same cycle) is nonzero.
REQ-022 FLUSH->RUN or FLUSH->IDLE, according to fetch_en, SHALL occur when the outstanding count reaches 0.
REQ-023 rom_req SHALL be 1 only in RUN with redirect=0 and outstanding+occupancy<DEPTH; a responded entry is never dropped for lack of space.
REQ-024 rom_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 on rom_req&rom_gnt and wrap modulo 2^ADDRESS_WIDTH.
REQ-025 Each rom_rvalid SHALL push {rom_rdata, pc of that request} into the buffer one cycle after the edge, except in FLUSH, where it is discarded.
REQ-026 The head SHALL pop on instr_valid&instr_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-027 instr_valid SHALL be combinational from occupancy>0; instr and instr_pc SHALL come directly from the head register.
REQ-028 On redirect, the buffer SHALL be emptied, fetch_pc SHALL be set to {redirect_pc[ADDRESS_WIDTH-1:2],2'b00}, and any same-cycle pop or push SHALL be ignored.
REQ-029 A redirect received in FLUSH SHALL reload fetch_pc and remain in FLUSH.
REQ-030 The minimum latency SHALL be 2 cycles from grant to instr_valid, given 1-cycle ROM latency.
REQ-031 The outstanding counter SHALL be $clog2(DEPTH)+1 bits wide; an rvalid with outstanding=0 is illegal and SHALL be flagged by an assertion.

Reset
REQ-032 While rst_n=0, the block SHALL be in IDLE with fetch_pc=RESET_PC, buffer empty, and outstanding=0.
REQ-033 During reset, outputs SHALL be: rom_req=0, rom_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-034 Reset mid-transaction SHALL abandon outstanding responses; the ROM is reset by the same rst_n.

Configuration
REQ-035 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs perf_fetch_cnt[31:0], which increments per grant, and perf_flush_cnt[31:0], which increments per redirect.
REQ-036 The perf counters SHALL wrap and SHALL reset to 0.
REQ-037 Without FETCH_PERF_CNT_EN, the perf ports and logic SHALL be absent.

Structure
REQ-038 Package fetch_pkg SHALL hold the fetch_state_t enum (IDLE, RUN, FLUSH), RESET_PC_DEFAULT, and typedef fetch_entry_t {instr, pc}.
REQ-039 The buffer SHALL be the sub-module fetch_fifo, a DEPTH-entry fifo of fetch_entry_t with push, pop, flush, count, and head.

Verification
REQ-040 Reset release, fetch_en=1, 1-cycle ROM with gnt=1: rom_addr SHALL be BFC00000, BFC00004, ..., and instr_pc=BFC00000 SHALL be valid in cycle 2.
REQ-041 instr_ready=0 for 10 cycles: exactly 4 requests granted, rom_req=0 thereafter, and no data loss after ready returns.
REQ-042 Redirect to 0xBFC00103 with 2 outstanding: FLUSH for 2 responses that are discarded, then the next rom_addr=BFC00100 and the first instr_pc=BFC00100.
REQ-043 Redirect on the same cycle as pop and rvalid: the buffer is empty the next cycle and no stale instr_valid appears.
REQ-044 fetch_pc=FFFFFFFC, granted: the next rom_addr=00000000.
REQ-045 rst_n low mid-fetch with 3 outstanding: rom_req=0 and instr_valid=0 immediately; fetch resumes from BFC00000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Raw encodings of fetch_state_t for the state register and the debug port.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer; flush wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0) && !flush;
    assign do_push = push && !flush && ((count_q != (PW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues ROM requests, buffers in-order responses,
// and flushes on redirect. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT[ADDRESS_WIDTH-1:0],
    parameter int                     DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     rom_req,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic                     rom_gnt,
    input  logic                     rom_rvalid,
    input  logic [DATA_WIDTH-1:0]    rom_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_flush_cnt,
`endif
    output logic [1:0]               dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    instr;
        logic [ADDRESS_WIDTH-1:0] pc;
    } fetch_slot_t;

    // Handshakes: a ROM request transfers on rom_req&rom_gnt, a response on
    // rom_rvalid (in order), and the head instruction on instr_valid&instr_ready.
    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]            outstanding_q, outstanding_d;
    logic [CW-1:0]            fifo_count;
    logic [CW:0]              inflight;
    logic [ADDRESS_WIDTH-1:0] redirect_aligned;
    logic                     grant;
    logic                     push;
    logic                     pop;
    fetch_slot_t              push_slot;
    fetch_slot_t              head_slot;
    logic                     unused_redirect_lo;

    assign redirect_aligned   = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Slots already claimed by in-flight requests count against buffer space,
    // so every response that arrives is guaranteed a place.
    assign inflight = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign rom_req  = (state_q == ST_RUN) && !redirect && (inflight < (CW+1)'(DEPTH));
    assign rom_addr = fetch_pc_q;
    assign grant    = rom_req && rom_gnt;

    assign outstanding_d = outstanding_q + CW'(grant) - CW'(rom_rvalid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fetch_en) state_d = ST_RUN;
            ST_RUN:   if (!fetch_en) state_d = ST_IDLE;
            ST_FLUSH: if (outstanding_d == '0) state_d = fetch_en ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect && (outstanding_d != '0)) state_d = ST_FLUSH;
    end

    // resp_pc tracks the address of the next response that will be kept;
    // fetch is sequential between redirects, so no per-request pc queue is needed.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
            if (push)  resp_pc_d  = resp_pc_q + ADDRESS_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign push            = rom_rvalid && (state_q != ST_FLUSH) && !redirect;
    assign pop             = instr_valid && instr_ready && !redirect;
    assign push_slot.instr = rom_rdata;
    assign push_slot.pc    = resp_pc_q;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_slot_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_slot),
        .pop       (pop),
        .flush     (redirect),
        .head      (head_slot),
        .count     (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = head_slot.instr;
    assign instr_pc    = head_slot.pc;
    assign dbg_state   = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (grant)    perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redirect) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) rom_rvalid |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small in-order ROM model of configurable latency.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_gnt;
    logic        rom_rvalid;
    logic [31:0] rom_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          gnt_cnt = 0;
    int          rom_lat = 1;
    logic [31:0] rom_pend_addr[$];
    int          rom_pend_cd[$];
    logic [31:0] exp_q[$];

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_gnt     (rom_gnt),
        .rom_rvalid  (rom_rvalid),
        .rom_rdata   (rom_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the grant, cross the edge, then advance the ROM model.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        #1;
        g = rom_req & rom_gnt;
        a = rom_addr;
        @(posedge clk);
        #1;
        if (g) begin
            gnt_cnt++;
            rom_pend_addr.push_back(a);
            rom_pend_cd.push_back(rom_lat);
        end
        foreach (rom_pend_cd[i]) rom_pend_cd[i] = rom_pend_cd[i] - 1;
        if (rom_pend_cd.size() > 0 && rom_pend_cd[0] == 0) begin
            rom_rvalid = 1'b1;
            rom_rdata  = ~rom_pend_addr[0];
            void'(rom_pend_addr.pop_front());
            void'(rom_pend_cd.pop_front());
        end else begin
            rom_rvalid = 1'b0;
            rom_rdata  = '0;
        end
        #1;
    endtask

    task automatic rom_reset();
        rom_pend_addr.delete();
        rom_pend_cd.delete();
        rom_rvalid = 1'b0;
        rom_rdata  = '0;
    endtask

    initial begin
        int k;
        logic [31:0] e;
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        rom_gnt     = 1'b0;
        instr_ready = 1'b0;
        rom_reset();
        tick();
        tick();
        chk("rst_rom_req",     32'(rom_req),     32'd0);
        chk("rst_rom_addr",    rom_addr,         32'hBFC0_0000);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr",       instr,            32'd0);
        chk("rst_instr_pc",    instr_pc,         32'd0);
        chk("rst_state",       32'(dbg_state),   32'(ST_IDLE));

        // Start-up with 1-cycle ROM, decode stalled.
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        rom_gnt  = 1'b1;
        rom_lat  = 1;
        gnt_cnt  = 0;
        tick();
        chk("start_req",   32'(rom_req),     32'd1);
        chk("start_addr0", rom_addr,         32'hBFC0_0000);
        tick();
        chk("start_addr1", rom_addr,         32'hBFC0_0004);
        chk("start_novld", 32'(instr_valid), 32'd0);
        tick();
        chk("lat2_valid",  32'(instr_valid), 32'd1);
        chk("lat2_pc",     instr_pc,         32'hBFC0_0000);
        chk("lat2_instr",  instr,            32'h403F_FFFF);
        chk("start_addr2", rom_addr,         32'hBFC0_0008);
        repeat (7) tick();
        chk("stall_grants", 32'(gnt_cnt),     32'd4);
        chk("stall_req",    32'(rom_req),     32'd0);
        chk("stall_valid",  32'(instr_valid), 32'd1);
        chk("stall_head",   instr_pc,         32'hBFC0_0000);

        // Release decode: the buffered words drain in order with no loss.
        instr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'hBFC0_0000 + 32'(4 * i));
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            chk("drain_pc",    instr_pc, e);
            chk("drain_instr", instr,    ~e);
        end

        // Redirect in the same cycle as a pop and an rvalid.
        redirect    = 1'b1;
        redirect_pc = 32'hBFC0_0200;
        tick();
        redirect = 1'b0;
        chk("rd_same_empty", 32'(instr_valid), 32'd0);
        chk("rd_same_state", 32'(dbg_state),   32'(ST_RUN));
        tick();
        chk("rd_same_nostale", 32'(instr_valid), 32'd0);
        chk("rd_same_addr",    rom_addr,         32'hBFC0_0204);
        tick();
        chk("rd_same_valid", 32'(instr_valid), 32'd1);
        chk("rd_same_pc",    instr_pc,         32'hBFC0_0200);

        // Reset with 3 outstanding requests (3-cycle ROM, decode stalled).
        rst_n = 1'b0;
        rom_reset();
        tick();
        rst_n       = 1'b1;
        rom_lat     = 3;
        instr_ready = 1'b0;
        repeat (5) tick();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        chk("pre_rst_pc",    instr_pc,         32'hBFC0_0000);
        rst_n = 1'b0;
        rom_reset();
        #1;
        chk("midrst_req",   32'(rom_req),     32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instr,            32'd0);
        chk("midrst_addr",  rom_addr,         32'hBFC0_0000);
        tick();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("resume_req",  32'(rom_req), 32'd1);
        chk("resume_addr", rom_addr,     32'hBFC0_0000);

        // Redirect with 2 outstanding: both responses discarded in FLUSH.
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hBFC0_0103;
        tick();
        redirect = 1'b0;
        chk("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
        chk("flush_req",   32'(rom_req),   32'd0);
        chk("flush_addr",  rom_addr,       32'hBFC0_0100);
        tick();
        chk("flush_state2", 32'(dbg_state),   32'(ST_FLUSH));
        chk("flush_novld",  32'(instr_valid), 32'd0);
        tick();
        chk("flush_exit",  32'(dbg_state),   32'(ST_RUN));
        chk("flush_req2",  32'(rom_req),     32'd1);
        chk("flush_addr2", rom_addr,         32'hBFC0_0100);
        chk("flush_novld2", 32'(instr_valid), 32'd0);
        k = 0;
        while (!instr_valid && k < 10) begin
            tick();
            k++;
        end
        chk("flush_first_valid", 32'(instr_valid), 32'd1);
        chk("flush_first_pc",    instr_pc,         32'hBFC0_0100);
        chk("flush_first_instr", instr,            32'h403F_FEFF);

        // Address wrap at the top of the space.
        rom_lat     = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        k = 0;
        while (!rom_req && k < 10) begin
            tick();
            k++;
        end
        chk("wrap_req",   32'(rom_req), 32'd1);
        chk("wrap_addr0", rom_addr,     32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", rom_addr, 32'h0000_0000);
        tick();
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_pc0",   instr_pc,         32'hFFFF_FFFC);
        tick();
        chk("wrap_pc1",    instr_pc, 32'h0000_0000);
        chk("wrap_instr1", instr,    32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
